risc_v_32_bypass_scoreboard: RTL and testbench
==============================================

Name: risc_v_32_bypass_scoreboard

Overview:
- Generalised operand-bypass and hazard unit for the RV32IM pipeline. It sits between register-file read and the EX stage.
- Each of NREAD source operands is selected from NFWD in-order pipeline stages, from a long-latency (MUL/DIV) writeback port, or from the register file.
- A per-register scoreboard tracks outstanding long-latency results, and the unit raises a stall on load-use, pending-result and WAW hazards.
- A saturating counter accumulates stall cycles for performance monitoring.

Parameters:
- XLEN, 32, data width.
- NREAD, 2, number of source operand ports.
- NFWD, 2, number of forwarding stages. Index 0 is the youngest (EX/MEM); NFWD-1 is the oldest.
- CNTW, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rs  in  NREAD*5  source register indices; port i is bits [5i+4:5i].
- rf_data  in  NREAD*XLEN  register-file read data per port.
- fwd_wreg  in  NFWD  stage k will write rd.
- fwd_rd  in  NFWD*5  destination register per stage.
- fwd_data  in  NFWD*XLEN  result per stage.
- fwd_rdy  in  NFWD  result in stage k is available now (0 for a load still in EX/MEM).
- issue_valid  in  1  an instruction leaves ID this cycle.
- issue_long  in  1  the issuing instruction is MUL/DIV (result arrives via lwb).
- issue_rd  in  5  destination of the issuing instruction.
- lwb_valid  in  1  long-latency result writes back this cycle.
- lwb_rd  in  5  long-latency destination.
- lwb_data  in  XLEN  long-latency result.
- cnt_clr  in  1  synchronous clear of stall_count.
- opnd  out  NREAD*XLEN  selected operand per port.
- stall  out  1  hold ID/IF and insert a bubble into EX.
- pending  out  32  scoreboard view; bit r means register r awaits a long result.
- stall_count  out  CNTW  saturating count of stall cycles.

Behaviour:
- Reset (async, rst=1): pending=0 and stall_count=0, effective immediately. During reset opnd and stall remain combinational on their inputs, with pending forced to 0.

Operand select (combinational, zero latency), per port i with s=rs[i]:
- If s==0: opnd=0. x0 never matches and never stalls.
- Otherwise take the lowest k with fwd_wreg[k] && fwd_rd[k]==s; opnd=fwd_data[k]. The youngest stage wins.
- Else if lwb_valid && lwb_rd==s: opnd=lwb_data.
- Else opnd=rf_data[i].

Stall (combinational) is the OR over all ports with s!=0 of:
- (a) load-use: the winning stage k has fwd_rdy[k]=0.
- (b) pending: pending[s]=1, no forwarding stage matches, and not (lwb_valid && lwb_rd==s).

Stall is additionally asserted for:
- (c) WAW: issue_valid && issue_long && issue_rd!=0 && pending[issue_rd] && !(lwb_valid && lwb_rd==issue_rd).

Scoreboard (registered, updated at posedge clk):
- An issue is accepted only when issue_valid && !stall. An issue_valid while stall=1 has no effect.
- Accepted issue with issue_long && issue_rd!=0: set pending[issue_rd].
- lwb_valid && lwb_rd!=0: clear pending[lwb_rd].
- If the same register is set and cleared in the same cycle, set wins (the new long op owns it).
- pending[0] is always 0.
- lwb_valid for a register whose pending bit is 0 is legal and has no scoreboard effect.
- An accepted non-long issue to a pending rd does not change pending.

Stall counter (registered):
- cnt_clr has priority and loads 0.
- Otherwise, if stall=1, increment, saturating at 2^CNTW-1 (no wrap).

Test Plan:
- Forward priority, NFWD=2: rs0=5; stage0 and stage1 both write x5 with 0xAAAA0000 and 0x5555FFFF, fwd_rdy=11 -> opnd0=0xAAAA0000, stall=0.
- x0 guard: rs0=0, stage0 writes x0 with 0x12345678 -> opnd0=0, stall=0.
- Load-use: stage0 wreg=1, rd=7, fwd_rdy[0]=0, rs1=7 -> stall=1 and stall_count increments by 1 per cycle. Next cycle with fwd_rdy[0]=1 and data 0xDEAD -> stall=0, opnd1=0xDEAD.
- Scoreboard lifecycle: accept a long issue to x9 -> pending[9]=1 next cycle.
  - rs0=9 with no stage match -> stall=1 until lwb_valid, lwb_rd=9, lwb_data=0xCAFE.
  - In that lwb cycle stall=0 and opnd0=0xCAFE; pending[9]=0 the cycle after.
- Set/clear collision and WAW:
  - With pending[3]=1, a long issue to x3 together with lwb_rd=3 -> no stall, pending[3] stays 1.
  - Long issue to x3 with pending[3]=1 and no lwb -> stall=1, pending unchanged.
- Reset/saturation:
  - Assert rst mid-operation with pending=0x00000210 and stall_count=7 -> both 0 immediately.
  - With CNTW=3 and stall held for 10 cycles -> stall_count=7.
  - cnt_clr -> 0.

Source files
------------

// File: rtl/risc_v_32_bypass_scoreboard.sv
// risc_v_32_bypass_scoreboard
//
// Operand-bypass and hazard unit between register-file read and EX.
// Each source operand is taken from the youngest matching in-order
// forwarding stage, else from the long-latency (MUL/DIV) writeback port,
// else from the register file. A per-register scoreboard tracks
// outstanding long-latency results. Stall is raised on load-use,
// pending-result and WAW hazards. A saturating counter accumulates
// stall cycles.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rs              NREAD x 5-bit source indices (port i = bits [5i+4:5i])
//   rf_data         NREAD x XLEN register-file read data
//   fwd_wreg/rd/data/rdy  per forwarding stage (index 0 = youngest)
//   issue_valid/long/rd   instruction leaving ID this cycle
//   lwb_valid/rd/data     long-latency writeback
//   cnt_clr         synchronous clear of stall_count
//   opnd            NREAD x XLEN selected operands
//   stall           hold ID/IF, bubble into EX
//   pending         scoreboard, bit r = register r awaits a long result
//   stall_count     saturating stall-cycle count
//
// Handshake: an issue is accepted on a rising clock edge when
// issue_valid && !stall; issue_valid while stall=1 has no effect.
module risc_v_32_bypass_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREAD = 2,
    parameter int NFWD  = 2,
    parameter int CNTW  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*5-1:0]    rs,
    input  logic [NREAD*XLEN-1:0] rf_data,
    input  logic [NFWD-1:0]       fwd_wreg,
    input  logic [NFWD*5-1:0]     fwd_rd,
    input  logic [NFWD*XLEN-1:0]  fwd_data,
    input  logic [NFWD-1:0]       fwd_rdy,
    input  logic                  issue_valid,
    input  logic                  issue_long,
    input  logic [4:0]            issue_rd,
    input  logic                  lwb_valid,
    input  logic [4:0]            lwb_rd,
    input  logic [XLEN-1:0]       lwb_data,
    input  logic                  cnt_clr,
    output logic [NREAD*XLEN-1:0] opnd,
    output logic                  stall,
    output logic [31:0]           pending,
    output logic [CNTW-1:0]       stall_count
);

    logic [31:0]      pending_q;
    logic [31:0]      pending_d;
    logic [31:0]      set_vec;
    logic [31:0]      clr_vec;
    logic [NREAD-1:0] port_stall;
    logic             waw_stall;
    logic [CNTW-1:0]  count_q;

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        logic [4:0]      s;
        logic            fwd_hit;
        logic            fwd_ok;
        logic [XLEN-1:0] fwd_val;
        logic            lwb_hit;

        assign s = rs[5*i +: 5];

        // Scan oldest to youngest so the youngest matching stage is the
        // last one written and therefore wins.
        always_comb begin
            fwd_hit = 1'b0;
            fwd_ok  = 1'b1;
            fwd_val = '0;
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (fwd_wreg[k] && (fwd_rd[5*k +: 5] == s)) begin
                    fwd_hit = 1'b1;
                    fwd_ok  = fwd_rdy[k];
                    fwd_val = fwd_data[XLEN*k +: XLEN];
                end
            end
        end

        assign lwb_hit = lwb_valid && (lwb_rd == s);

        assign opnd[XLEN*i +: XLEN] = (s == 5'd0) ? '0 :
                                      fwd_hit     ? fwd_val :
                                      lwb_hit     ? lwb_data :
                                                    rf_data[XLEN*i +: XLEN];

        // A matching stage takes precedence over the scoreboard: the
        // in-order producer is younger than any outstanding long op.
        assign port_stall[i] = (s != 5'd0) &&
                               ((fwd_hit && !fwd_ok) ||
                                (!fwd_hit && pending_q[s] && !lwb_hit));
    end

    // A second long op to a still-pending rd must wait, unless the first
    // one is writing back in this very cycle.
    assign waw_stall = issue_valid && issue_long && (issue_rd != 5'd0) &&
                       pending_q[issue_rd] &&
                       !(lwb_valid && (lwb_rd == issue_rd));

    assign stall = (|port_stall) || waw_stall;

    assign set_vec = (issue_valid && !stall && issue_long && (issue_rd != 5'd0))
                     ? (32'd1 << issue_rd) : 32'd0;
    assign clr_vec = (lwb_valid && (lwb_rd != 5'd0)) ? (32'd1 << lwb_rd) : 32'd0;

    // Set is applied after clear so a new long op owns a register that is
    // written back in the same cycle.
    always_comb begin
        pending_d    = (pending_q & ~clr_vec) | set_vec;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (cnt_clr) begin
            count_q <= '0;
        end else if (stall && (count_q != {CNTW{1'b1}})) begin
            count_q <= count_q + CNTW'(1);
        end
    end

    assign pending     = pending_q;
    assign stall_count = count_q;

endmodule

// File: tb/tb_risc_v_32_bypass_scoreboard.sv
module tb_risc_v_32_bypass_scoreboard;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  rs;
  logic [63:0] rf_data;
  logic [1:0]  fwd_wreg;
  logic [9:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic [1:0]  fwd_rdy;
  logic        issue_valid;
  logic        issue_long;
  logic [4:0]  issue_rd;
  logic        lwb_valid;
  logic [4:0]  lwb_rd;
  logic [31:0] lwb_data;
  logic        cnt_clr;
  logic [63:0] opnd;
  logic        stall;
  logic [31:0] pending;
  logic [31:0] stall_count;
  logic [63:0] opnd_s;
  logic        stall_s;
  logic [31:0] pending_s;
  logic [2:0]  stall_count_s;

  risc_v_32_bypass_scoreboard dut (
    .clk(clk), .rst(rst), .rs(rs), .rf_data(rf_data),
    .fwd_wreg(fwd_wreg), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_rdy(fwd_rdy),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
    .lwb_valid(lwb_valid), .lwb_rd(lwb_rd), .lwb_data(lwb_data),
    .cnt_clr(cnt_clr), .opnd(opnd), .stall(stall), .pending(pending),
    .stall_count(stall_count)
  );

  risc_v_32_bypass_scoreboard #(.CNTW(3)) dut_sat (
    .clk(clk), .rst(rst), .rs(rs), .rf_data(rf_data),
    .fwd_wreg(fwd_wreg), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_rdy(fwd_rdy),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
    .lwb_valid(lwb_valid), .lwb_rd(lwb_rd), .lwb_data(lwb_data),
    .cnt_clr(cnt_clr), .opnd(opnd_s), .stall(stall_s), .pending(pending_s),
    .stall_count(stall_count_s)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    rs = '0; rf_data = '0; fwd_wreg = '0; fwd_rd = '0; fwd_data = '0;
    fwd_rdy = 2'b11; issue_valid = 1'b0; issue_long = 1'b0; issue_rd = '0;
    lwb_valid = 1'b0; lwb_rd = '0; lwb_data = '0; cnt_clr = 1'b0;
  endtask

  // one clock edge, then land on the falling edge to drive/sample
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic lng, input logic [4:0] rd);
    issue_valid = 1'b1; issue_long = lng; issue_rd = rd;
  endtask

  task automatic no_issue();
    issue_valid = 1'b0; issue_long = 1'b0; issue_rd = '0;
  endtask

  // combinational vector table, applied with pending == 0
  typedef struct {
    string       name;
    logic [9:0]  rs;
    logic [63:0] rf;
    logic [1:0]  wreg;
    logic [9:0]  rd;
    logic [63:0] fdata;
    logic [1:0]  rdy;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        es;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"fwd_priority", {5'd0, 5'd5}, {32'h1111_1111, 32'h2222_2222}, 2'b11, {5'd5, 5'd5},
                {32'h5555_FFFF, 32'hAAAA_0000}, 2'b11, 1'b0, 5'd0, 32'h0,
                32'hAAAA_0000, 32'h0, 1'b0};
    vecs[1] = '{"x0_guard", {5'd3, 5'd0}, {32'h0000_0033, 32'h9999_9999}, 2'b01, {5'd0, 5'd0},
                {32'h0, 32'h1234_5678}, 2'b11, 1'b0, 5'd0, 32'h0,
                32'h0, 32'h0000_0033, 1'b0};
    vecs[2] = '{"stage1_only", {5'd6, 5'd6}, {32'h1, 32'h2}, 2'b10, {5'd6, 5'd0},
                {32'h0000_0066, 32'h0000_0099}, 2'b11, 1'b0, 5'd0, 32'h0,
                32'h0000_0066, 32'h0000_0066, 1'b0};
    vecs[3] = '{"lwb_bypass", {5'd4, 5'd8}, {32'h0000_0044, 32'h0000_0088}, 2'b00, {5'd0, 5'd0},
                {32'h0, 32'h0}, 2'b11, 1'b1, 5'd8, 32'h0000_BEEF,
                32'h0000_BEEF, 32'h0000_0044, 1'b0};
    vecs[4] = '{"fwd_over_lwb", {5'd0, 5'd8}, {32'h0, 32'h0000_0088}, 2'b10, {5'd8, 5'd0},
                {32'h0000_0011, 32'h0}, 2'b11, 1'b1, 5'd8, 32'h0000_0022,
                32'h0000_0011, 32'h0, 1'b0};
    vecs[5] = '{"load_use_s1", {5'd7, 5'd0}, {32'h0, 32'h0}, 2'b10, {5'd7, 5'd0},
                {32'h0000_0077, 32'h0}, 2'b00, 1'b0, 5'd0, 32'h0,
                32'h0, 32'h0000_0077, 1'b1};
    vecs[6] = '{"young_ready", {5'd0, 5'd7}, {32'h0, 32'h0}, 2'b11, {5'd7, 5'd7},
                {32'h0000_0070, 32'h0000_0071}, 2'b01, 1'b0, 5'd0, 32'h0,
                32'h0000_0071, 32'h0, 1'b0};
    vecs[7] = '{"x0_no_stall", {5'd0, 5'd0}, {32'h5, 32'h6}, 2'b01, {5'd0, 5'd0},
                {32'h0, 32'hFFFF_FFFF}, 2'b00, 1'b1, 5'd0, 32'h7,
                32'h0, 32'h0, 1'b0};
    vecs[8] = '{"rf_fallthru", {5'd2, 5'd1}, {32'hB0B0_0002, 32'hA0A0_0001}, 2'b11, {5'd9, 5'd10},
                {32'h3, 32'h4}, 2'b00, 1'b1, 5'd11, 32'h5,
                32'hA0A0_0001, 32'hB0B0_0002, 1'b0};
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    #12;
    // reset state
    check("reset_pending", pending, 32'h0);
    check("reset_count", stall_count, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // table-driven combinational checks
    for (int v = 0; v < 9; v++) begin
      clear_inputs();
      rs = vecs[v].rs; rf_data = vecs[v].rf; fwd_wreg = vecs[v].wreg;
      fwd_rd = vecs[v].rd; fwd_data = vecs[v].fdata; fwd_rdy = vecs[v].rdy;
      lwb_valid = vecs[v].lv; lwb_rd = vecs[v].lrd; lwb_data = vecs[v].ldata;
      #1;
      check({vecs[v].name, "_opnd0"}, opnd[31:0], vecs[v].e0);
      check({vecs[v].name, "_opnd1"}, opnd[63:32], vecs[v].e1);
      check({vecs[v].name, "_stall"}, {31'b0, stall}, {31'b0, vecs[v].es});
      step();
    end

    // load-use: count starts from a cleared counter
    clear_inputs();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    fwd_wreg = 2'b01; fwd_rd = {5'd0, 5'd7}; fwd_rdy = 2'b10; rs = {5'd7, 5'd0};
    #1;
    check("lu_stall", {31'b0, stall}, 32'h1);
    step();
    check("lu_count1", stall_count, 32'h1);
    step();
    check("lu_count2", stall_count, 32'h2);
    fwd_rdy = 2'b11; fwd_data = {32'h0, 32'h0000_DEAD};
    #1;
    check("lu_release_stall", {31'b0, stall}, 32'h0);
    check("lu_release_opnd1", opnd[63:32], 32'h0000_DEAD);
    step();
    check("lu_count_hold", stall_count, 32'h2);

    // scoreboard lifecycle on x9
    clear_inputs();
    issue(1'b1, 5'd9);
    #1;
    check("sb_issue_nostall", {31'b0, stall}, 32'h0);
    step();
    no_issue();
    check("sb_set9", pending, 32'h0000_0200);
    rs = {5'd0, 5'd9}; rf_data = {32'h0, 32'h0000_0999};
    #1;
    check("sb_pend_stall", {31'b0, stall}, 32'h1);
    // issue while stalled must not be accepted
    issue(1'b1, 5'd12);
    step();
    no_issue();
    check("sb_stalled_issue_ignored", pending, 32'h0000_0200);
    check("sb_still_stall", {31'b0, stall}, 32'h1);
    lwb_valid = 1'b1; lwb_rd = 5'd9; lwb_data = 32'h0000_CAFE;
    #1;
    check("sb_lwb_nostall", {31'b0, stall}, 32'h0);
    check("sb_lwb_opnd0", opnd[31:0], 32'h0000_CAFE);
    step();
    lwb_valid = 1'b0;
    check("sb_clear9", pending, 32'h0);
    #1;
    check("sb_rf_after", opnd[31:0], 32'h0000_0999);

    // lwb for a non-pending register and long issue to x0: no effect
    clear_inputs();
    lwb_valid = 1'b1; lwb_rd = 5'd20; lwb_data = 32'h1;
    issue(1'b1, 5'd0);
    step();
    clear_inputs();
    check("sb_noop", pending, 32'h0);

    // set/clear collision and WAW on x3
    issue(1'b1, 5'd3);
    step();
    check("col_set3", pending, 32'h0000_0008);
    issue(1'b1, 5'd3);
    lwb_valid = 1'b1; lwb_rd = 5'd3; lwb_data = 32'h33;
    #1;
    check("col_nostall", {31'b0, stall}, 32'h0);
    step();
    lwb_valid = 1'b0;
    check("col_set_wins", pending, 32'h0000_0008);
    #1;
    check("waw_stall", {31'b0, stall}, 32'h1);
    step();
    check("waw_pend_same", pending, 32'h0000_0008);
    // accepted non-long issue to a pending rd leaves it pending
    issue(1'b0, 5'd3);
    #1;
    check("nonlong_nostall", {31'b0, stall}, 32'h0);
    step();
    check("nonlong_pend_same", pending, 32'h0000_0008);
    clear_inputs();
    lwb_valid = 1'b1; lwb_rd = 5'd3;
    step();
    clear_inputs();
    check("col_cleanup", pending, 32'h0);

    // reset mid-operation with pending=0x210 and stall_count=7
    issue(1'b1, 5'd4);
    step();
    issue(1'b1, 5'd9);
    step();
    no_issue();
    check("rst_pre_pend", pending, 32'h0000_0210);
    cnt_clr = 1'b1;
    fwd_wreg = 2'b01; fwd_rd = {5'd0, 5'd7}; fwd_rdy = 2'b10; rs = {5'd0, 5'd7};
    step();
    check("clr_priority", stall_count, 32'h0);
    cnt_clr = 1'b0;
    for (int c = 0; c < 7; c++) step();
    check("rst_pre_count", stall_count, 32'h7);
    rst = 1'b1;
    #1;
    check("rst_async_pend", pending, 32'h0);
    check("rst_async_count", stall_count, 32'h0);
    check("rst_async_count_sat", {29'b0, stall_count_s}, 32'h0);
    check("rst_stall_comb", {31'b0, stall}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // saturation: stall held 10 cycles
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int c = 0; c < 10; c++) step();
    check("sat_cntw3", {29'b0, stall_count_s}, 32'h7);
    check("nosat_cntw32", stall_count, 32'd10);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("sat_clr", {29'b0, stall_count_s}, 32'h0);
    check("sat_clr32", stall_count, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
